// File: rtl/pea_command_issuer_if.sv
// Request, payload and FIFO-write bundle for pea_command_issuer.
//   master : host / FIFO side. Drives the request, the payload and the full flags.
//   slave  : issuer side. Drives the handshakes, the FIFO strobes and the done/error pulses.
//   req_*            operation request (op, arg1, arg2) with valid/ready handshake
//   pay_*            payload word stream with valid/ready handshake
//   cmd_full         command FIFO full
//   data_full        data FIFO full
//   wr_out_command   command FIFO write strobe
//   data_out_command encoded command word
//   wr_out_data      data FIFO write strobe
//   data_out_data    payload word
//   done             request completed pulse
//   error            request rejected pulse
interface pea_command_issuer_if #(
  parameter int word_size = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [2:0]           req_arg1;
  logic [4:0]           req_arg2;
  logic                 pay_valid;
  logic                 pay_ready;
  logic [word_size-1:0] pay_data;
  logic                 cmd_full;
  logic                 data_full;
  logic                 wr_out_command;
  logic [word_size-1:0] data_out_command;
  logic                 wr_out_data;
  logic [word_size-1:0] data_out_data;
  logic                 done;
  logic                 error;

  modport master (
    output req_valid, req_op, req_arg1, req_arg2, pay_valid, pay_data, cmd_full, data_full,
    input  req_ready, pay_ready, wr_out_command, data_out_command, wr_out_data, data_out_data,
           done, error
  );

  modport slave (
    input  req_valid, req_op, req_arg1, req_arg2, pay_valid, pay_data, cmd_full, data_full,
    output req_ready, pay_ready, wr_out_command, data_out_command, wr_out_data, data_out_data,
           done, error
  );
endinterface

// File: rtl/pea_command_issuer.sv
// Host-side producer for the polynomial evaluation accelerator. Accepts one
// request (STP/EVP/EVB/RST), writes its payload words into the data FIFO and
// then the encoded command word into the command FIFO, so a command never
// becomes visible before all of its data.
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-low
//   bus   request/payload/FIFO bundle (slave side)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a request (req_ready=1)
// CHECK   | validate op, size payload, register the command word
// PAYLOAD | forward payload words to the data FIFO until count hits 0
// COMMAND | write the command word once the command FIFO has room
// DONE    | one-cycle done pulse
// ERR     | one-cycle error pulse, nothing was written
module pea_command_issuer #(
  parameter int word_size = 16
) (
  input logic                  clk,
  input logic                  rst,
  pea_command_issuer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, CHECK, PAYLOAD, COMMAND, DONE, ERR
  } state_t;

  localparam logic [2:0] OP_STP = 3'd1;
  localparam logic [2:0] OP_EVP = 3'd2;
  localparam logic [2:0] OP_EVB = 3'd3;
  localparam logic [2:0] OP_RST = 3'd5;

  state_t               state;
  logic [5:0]           cnt;
  logic [2:0]           op_q;
  logic [2:0]           arg1_q;
  logic [4:0]           arg2_q;
  logic [word_size-1:0] cmd_q;

  logic [5:0] pay_cnt;
  logic       illegal;
  logic       wr_data;
  logic       wr_cmd;

  // Payload size and legality are decoded from the latched request.
  always_comb begin
    pay_cnt = 6'd0;
    illegal = 1'b0;
    case (op_q)
      OP_STP:  pay_cnt = {1'b0, arg2_q} + 6'd1;
      OP_EVP:  pay_cnt = 6'd1;
      OP_EVB: begin
        pay_cnt = {1'b0, arg2_q};
        illegal = (arg2_q == 5'd0);
      end
      OP_RST:  pay_cnt = 6'd0;
      default: illegal = 1'b1;
    endcase
  end

  // Strobes are combinational on the full flags so a full drop and a
  // waiting word produce a write in the same cycle.
  assign wr_data = (state == PAYLOAD) & bus.pay_valid & ~bus.data_full;
  assign wr_cmd  = (state == COMMAND) & ~bus.cmd_full;

  assign bus.req_ready        = (state == IDLE);
  assign bus.pay_ready        = (state == PAYLOAD) & ~bus.data_full;
  assign bus.wr_out_data      = wr_data;
  assign bus.data_out_data    = bus.pay_data;
  assign bus.wr_out_command   = wr_cmd;
  assign bus.data_out_command = cmd_q;
  assign bus.done             = (state == DONE);
  assign bus.error            = (state == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      op_q   <= 3'd0;
      arg1_q <= 3'd0;
      arg2_q <= 5'd0;
      cmd_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op_q   <= bus.req_op;
            arg1_q <= bus.req_arg1;
            arg2_q <= bus.req_arg2;
            state  <= CHECK;
          end
        end
        CHECK: begin
          // instr field is 8 bits: 5 zero bits above the 3-bit op.
          cmd_q <= word_size'({arg2_q, arg1_q, 5'b00000, op_q});
          if (illegal) begin
            state <= ERR;
          end else if (pay_cnt == 6'd0) begin
            state <= COMMAND;
          end else begin
            cnt   <= pay_cnt;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (wr_data) begin
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) state <= COMMAND;
          end
        end
        COMMAND: begin
          if (wr_cmd) state <= DONE;
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pea_command_issuer.sv
// Scoreboard bench for pea_command_issuer: expected FIFO words are queued when
// a request is driven and popped by a negedge monitor on every strobe.
module tb_pea_command_issuer;
  localparam int WS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pea_command_issuer_if #(.word_size(WS)) ifc ();

  pea_command_issuer #(.word_size(WS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int n_vec = 0;
  int n_mis = 0;
  int n_wd  = 0;
  int n_wc  = 0;
  logic [WS-1:0] exp_data[$];
  logic [WS-1:0] exp_cmd[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ifc.wr_out_data) begin
      n_wd++;
      chk("data_full_guard", {31'd0, ifc.data_full}, 32'd0);
      if (exp_data.size() == 0) chk("data_unexpected", 32'd1, 32'd0);
      else chk("data_word", {16'd0, ifc.data_out_data}, {16'd0, exp_data.pop_front()});
    end
    if (ifc.wr_out_command) begin
      n_wc++;
      chk("cmd_full_guard", {31'd0, ifc.cmd_full}, 32'd0);
      if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'd1, 32'd0);
      else chk("cmd_word", {16'd0, ifc.data_out_command}, {16'd0, exp_cmd.pop_front()});
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic do_req(input logic [2:0] op, input logic [2:0] a1, input logic [4:0] a2);
    int g;
    ifc.req_valid = 1'b1;
    ifc.req_op    = op;
    ifc.req_arg1  = a1;
    ifc.req_arg2  = a2;
    g = 0;
    @(negedge clk);
    while (!ifc.req_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("req_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    ifc.req_valid = 1'b0;
  endtask

  task automatic push_word(input logic [WS-1:0] w);
    int   g;
    logic hs;
    ifc.pay_valid = 1'b1;
    ifc.pay_data  = w;
    g  = 0;
    hs = 1'b0;
    while (!hs && g < 100) begin
      @(negedge clk);
      hs = ifc.pay_ready;
      g++;
    end
    if (!hs) chk("pay_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Counts negedges from the handshake; records first cycle of each event (-1 = none).
  task automatic observe(input int lim, output int fwd, output int fwc, output int fdn,
                         output int fer);
    int cyc;
    cyc = 0; fwd = -1; fwc = -1; fdn = -1; fer = -1;
    while (fdn < 0 && fer < 0 && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (ifc.wr_out_data && fwd < 0)    fwd = cyc;
      if (ifc.wr_out_command && fwc < 0) fwc = cyc;
      if (ifc.done)  fdn = cyc;
      if (ifc.error) fer = cyc;
    end
    if (fdn < 0 && fer < 0) chk("observe_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_queues(input string tag);
    chk({tag, "_data_left"}, exp_data.size(), 32'd0);
    chk({tag, "_cmd_left"}, exp_cmd.size(), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, ifc.req_ready}, 32'd1);
    chk({tag, "_pay_ready"}, {31'd0, ifc.pay_ready}, 32'd0);
    chk({tag, "_wr_data"}, {31'd0, ifc.wr_out_data}, 32'd0);
    chk({tag, "_wr_cmd"}, {31'd0, ifc.wr_out_command}, 32'd0);
    chk({tag, "_done"}, {31'd0, ifc.done}, 32'd0);
    chk({tag, "_error"}, {31'd0, ifc.error}, 32'd0);
    chk({tag, "_cmd_word"}, {16'd0, ifc.data_out_command}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fwd, fwc, fdn, fer, wd0, wc0, g;
    logic [WS-1:0] w;
    logic [WS-1:0] stp_words[4];

    ifc.req_valid = 1'b0; ifc.req_op = 3'd0; ifc.req_arg1 = 3'd0; ifc.req_arg2 = 5'd0;
    ifc.pay_valid = 1'b0; ifc.pay_data = '0; ifc.cmd_full = 1'b0; ifc.data_full = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // RST op: command only, strobe at cycle 2, done at cycle 3
    @(posedge clk); #1;
    wd0 = n_wd;
    exp_cmd.push_back(16'h0005);
    do_req(3'd5, 3'd0, 5'd0);
    observe(20, fwd, fwc, fdn, fer);
    chk("rst_cmd_latency", fwc, 32'd2);
    chk("rst_done_latency", fdn, 32'd3);
    chk("rst_no_data", n_wd - wd0, 32'd0);
    chk_queues("rst");

    // STP A=2 N=3
    @(posedge clk); #1;
    stp_words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    foreach (stp_words[i]) exp_data.push_back(stp_words[i]);
    exp_cmd.push_back(16'h1A01);
    do_req(3'd1, 3'd2, 5'd3);
    foreach (stp_words[i]) push_word(stp_words[i]);
    ifc.pay_valid = 1'b0;
    observe(20, fwd, fwc, fdn, fer);
    chk("stp_done", {31'd0, fdn > 0}, 32'd1);
    chk_queues("stp");

    // EVB b=2 with data_full high for 3 cycles mid-stream
    @(posedge clk); #1;
    exp_data.push_back(16'h0100);
    exp_data.push_back(16'h0200);
    exp_cmd.push_back(16'h1103);
    do_req(3'd3, 3'd1, 5'd2);
    fork
      begin
        push_word(16'h0100);
        push_word(16'h0200);
        ifc.pay_valid = 1'b0;
      end
      begin
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!ifc.wr_out_data && g < 20);
        @(posedge clk); #1;
        ifc.data_full = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("evb_no_wr_while_full", {31'd0, ifc.wr_out_data}, 32'd0);
          chk("evb_pay_ready_low", {31'd0, ifc.pay_ready}, 32'd0);
        end
        @(posedge clk); #1;
        ifc.data_full = 1'b0;
        @(negedge clk);
        chk("evb_full_drop_write", {31'd0, ifc.wr_out_data}, 32'd1);
      end
    join
    observe(20, fwd, fwc, fdn, fer);
    chk("evb_done", {31'd0, fdn > 0}, 32'd1);
    chk_queues("evb");

    // Illegal op 4
    @(posedge clk); #1;
    wd0 = n_wd; wc0 = n_wc;
    do_req(3'd4, 3'd0, 5'd0);
    observe(10, fwd, fwc, fdn, fer);
    chk("op4_error_cycle", fer, 32'd2);
    chk("op4_no_done", fdn, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("op4_ready_back", {31'd0, ifc.req_ready}, 32'd1);
    chk("op4_no_writes", (n_wd - wd0) + (n_wc - wc0), 32'd0);

    // EVB with b=0
    @(posedge clk); #1;
    wd0 = n_wd; wc0 = n_wc;
    do_req(3'd3, 3'd6, 5'd0);
    observe(10, fwd, fwc, fdn, fer);
    chk("evb0_error_cycle", fer, 32'd2);
    @(negedge clk);
    chk("evb0_ready_back", {31'd0, ifc.req_ready}, 32'd1);
    chk("evb0_no_writes", (n_wd - wd0) + (n_wc - wc0), 32'd0);

    // EVP A=7 with cmd_full held
    @(posedge clk); #1;
    ifc.cmd_full = 1'b1;
    exp_data.push_back(16'h00FF);
    exp_cmd.push_back(16'h0702);
    do_req(3'd2, 3'd7, 5'd0);
    push_word(16'h00FF);
    ifc.pay_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("evp_cmd_held_off", {31'd0, ifc.wr_out_command}, 32'd0);
    end
    @(posedge clk); #1;
    ifc.cmd_full = 1'b0;
    @(negedge clk);
    chk("evp_cmd_first_free", {31'd0, ifc.wr_out_command}, 32'd1);
    observe(10, fwd, fwc, fdn, fer);
    chk("evp_done", {31'd0, fdn > 0}, 32'd1);
    chk_queues("evp");

    // STP N=31: maximum payload of 32 random words
    @(posedge clk); #1;
    wd0 = n_wd;
    exp_cmd.push_back(16'hFD01);
    do_req(3'd1, 3'd5, 5'd31);
    for (int i = 0; i < 32; i++) begin
      w = WS'($urandom_range(0, 16'hFFFF));
      exp_data.push_back(w);
      push_word(w);
    end
    ifc.pay_valid = 1'b0;
    observe(20, fwd, fwc, fdn, fer);
    chk("stp32_count", n_wd - wd0, 32'd32);
    chk_queues("stp32");

    // Reset in the middle of an STP after 2 of 4 words
    @(posedge clk); #1;
    wd0 = n_wd;
    foreach (stp_words[i]) exp_data.push_back(stp_words[i] + 16'h0A00);
    exp_cmd.push_back(16'h1B01);
    do_req(3'd1, 3'd3, 5'd3);
    push_word(stp_words[0] + 16'h0A00);
    push_word(stp_words[1] + 16'h0A00);
    ifc.pay_data  = stp_words[2] + 16'h0A00;
    ifc.pay_valid = 1'b1;
    exp_data.delete();
    exp_cmd.delete();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("mid_reset");
    chk("mid_reset_words", n_wd - wd0, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    ifc.pay_valid = 1'b0;

    // EVP A=4 after reset, payload already waiting: write at 2, command at 3, done at 4
    @(posedge clk); #1;
    exp_data.push_back(16'h1234);
    exp_cmd.push_back(16'h0402);
    ifc.pay_valid = 1'b1;
    ifc.pay_data  = 16'h1234;
    do_req(3'd2, 3'd4, 5'd0);
    observe(20, fwd, fwc, fdn, fer);
    ifc.pay_valid = 1'b0;
    chk("post_evp_data_latency", fwd, 32'd2);
    chk("post_evp_cmd_latency", fwc, 32'd3);
    chk("post_evp_done_latency", fdn, 32'd4);
    chk_queues("post_evp");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
